// File: rtl/aes_key_expand.sv
// AES-128 key schedule: loads a cipher key on key_start and streams round keys 0..NR
// over a valid/ready handshake, one key per accepted beat.

module aes_sbox (
    input  logic [7:0] data,
    output logic [7:0] sub
);
    // Forward S-box, index 0 first.
    localparam logic [0:255][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign sub = SBOX[data];
endmodule

module aes_key_expand #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] key_in,
    input  logic         key_start,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_index,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic         key_busy,
    output logic         expand_done
);
    if (NR != 10) begin : g_bad_nr
        $error("aes_key_expand supports only NR = 10 (AES-128)");
    end

    localparam logic [3:0] LAST_INDEX = 4'(NR);

    typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;
    state_t state_reg;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  rot_word, sub_word, t_word;
    logic [31:0]  w0_next, w1_next, w2_next, w3_next;
    logic [127:0] key_next;
    logic [7:0]   rcon_next;
    logic         beat_accepted;

    function automatic logic [7:0] rcon_lookup(input logic [3:0] round);
        case (round)
            4'd1:    rcon_lookup = 8'h01;
            4'd2:    rcon_lookup = 8'h02;
            4'd3:    rcon_lookup = 8'h04;
            4'd4:    rcon_lookup = 8'h08;
            4'd5:    rcon_lookup = 8'h10;
            4'd6:    rcon_lookup = 8'h20;
            4'd7:    rcon_lookup = 8'h40;
            4'd8:    rcon_lookup = 8'h80;
            4'd9:    rcon_lookup = 8'h1b;
            4'd10:   rcon_lookup = 8'h36;
            default: rcon_lookup = 8'h00;
        endcase
    endfunction

    assign {w0, w1, w2, w3} = rk_out;
    assign rot_word  = {w3[23:0], w3[31:24]};
    assign rcon_next = rcon_lookup(rk_index + 4'd1);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sbox
            aes_sbox u_sbox (
                .data (rot_word[gi*8 +: 8]),
                .sub  (sub_word[gi*8 +: 8])
            );
        end
    endgenerate

    // Each new word chains off the one just produced, giving the 4-XOR ripple.
    assign t_word   = sub_word ^ {rcon_next, 24'h0};
    assign w0_next  = w0 ^ t_word;
    assign w1_next  = w1 ^ w0_next;
    assign w2_next  = w2 ^ w1_next;
    assign w3_next  = w3 ^ w2_next;
    assign key_next = {w0_next, w1_next, w2_next, w3_next};

    assign beat_accepted = rk_valid && rk_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            rk_out      <= '0;
            rk_index    <= '0;
            rk_valid    <= 1'b0;
            key_busy    <= 1'b0;
            expand_done <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (key_start) begin
                        rk_out    <= key_in;
                        rk_index  <= '0;
                        rk_valid  <= 1'b1;
                        key_busy  <= 1'b1;
                        state_reg <= EMIT;
                    end
                end
                EMIT: begin
                    // Without an accept the beat is held exactly as presented.
                    if (beat_accepted) begin
                        if (rk_index == LAST_INDEX) begin
                            rk_valid    <= 1'b0;
                            expand_done <= 1'b1;
                            state_reg   <= DONE;
                        end else begin
                            rk_out   <= key_next;
                            rk_index <= rk_index + 4'd1;
                        end
                    end
                end
                DONE: begin
                    expand_done <= 1'b0;
                    key_busy    <= 1'b0;
                    state_reg   <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand: expected round keys are queued at start and
// popped as each beat is accepted.

module tb_aes_key_expand;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] key_in;
    logic         key_start;
    logic [127:0] rk_out;
    logic [3:0]   rk_index;
    logic         rk_valid;
    logic         rk_ready;
    logic         key_busy;
    logic         expand_done;

    always #5 clk = ~clk;

    aes_key_expand #(.NR(10)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_in      (key_in),
        .key_start   (key_start),
        .rk_out      (rk_out),
        .rk_index    (rk_index),
        .rk_valid    (rk_valid),
        .rk_ready    (rk_ready),
        .key_busy    (key_busy),
        .expand_done (expand_done)
    );

    typedef struct packed {
        logic [3:0]   idx;
        logic [127:0] key;
        logic         chk;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    // FIPS-197 A.1 round keys.
    logic [127:0] a1_keys [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%032h expected=%032h", tag, obs, exp);
        end
    endtask

    task automatic push(input int idx, input logic [127:0] key, input logic check_key);
        sb_q.push_back('{idx: 4'(idx), key: key, chk: check_key});
    endtask

    task automatic push_a1();
        for (int i = 0; i <= 10; i++) push(i, a1_keys[i], 1'b1);
    endtask

    // Pushes idx0/idx1/idx10 as checked values and the interior keys as index-only.
    task automatic push_sparse(input logic [127:0] k0, input logic [127:0] k1, input logic [127:0] k10,
                               input logic check_last);
        push(0, k0, 1'b1);
        push(1, k1, 1'b1);
        for (int i = 2; i <= 9; i++) push(i, '0, 1'b0);
        push(10, k10, check_last);
    endtask

    task automatic start_key(input logic [127:0] k);
        key_in    = k;
        key_start = 1'b1;
        @(posedge clk); #1;
        key_start = 1'b0;
    endtask

    // Runs one schedule to completion, popping and comparing each accepted beat.
    task automatic drain(input string tag, input int ready_pct, input int inject_idx,
                         input logic [127:0] inject_key, input bit start_in_done, output int cycles);
        bit           stall_prev = 0;
        bit           injected   = 0;
        bit           done       = 0;
        logic [127:0] prev_out   = '0;
        logic [3:0]   prev_idx   = '0;
        logic [127:0] last_key   = '0;
        logic         last_chk   = 1'b0;
        exp_t         e;
        cycles = 0;
        while (!done && cycles < 200) begin
            rk_ready = ($urandom_range(99) < ready_pct);
            if (!injected && inject_idx >= 0 && rk_valid && rk_index == 4'(inject_idx)) begin
                key_in    = inject_key;
                key_start = 1'b1;
                injected  = 1;
            end
            if (stall_prev) begin
                chk({tag, " hold key"}, rk_out, prev_out);
                chk({tag, " hold idx"}, 128'(rk_index), 128'(prev_idx));
            end
            if (rk_valid && rk_ready) begin
                if (sb_q.size() == 0) begin
                    chk({tag, " unexpected beat"}, 128'(rk_valid), 128'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk({tag, " idx"}, 128'(rk_index), 128'(e.idx));
                    if (e.chk) chk({tag, " key"}, rk_out, e.key);
                    last_key = e.key;
                    last_chk = e.chk;
                end
            end
            stall_prev = rk_valid && !rk_ready;
            prev_out   = rk_out;
            prev_idx   = rk_index;
            @(posedge clk); #1;
            key_start = 1'b0;
            cycles++;
            if (expand_done) done = 1;
        end
        chk({tag, " done seen"}, 128'(done), 128'd1);
        chk({tag, " all beats"}, 128'(sb_q.size()), 128'd0);
        chk({tag, " busy at done"}, 128'(key_busy), 128'd1);
        sb_q.delete();
        if (start_in_done) begin
            key_in    = '1;
            key_start = 1'b1;
        end
        @(posedge clk); #1;
        key_start = 1'b0;
        chk({tag, " busy after done"}, 128'(key_busy), 128'd0);
        chk({tag, " done pulse width"}, 128'(expand_done), 128'd0);
        chk({tag, " valid after done"}, 128'(rk_valid), 128'd0);
        if (last_chk) chk({tag, " last key held"}, rk_out, last_key);
        $display("%s: schedule finished after %0d cycles", tag, cycles + 1);
    endtask

    initial begin
        int cyc;
        bit saw_done;

        rst_n     = 1'b0;
        key_in    = '0;
        key_start = 1'b0;
        rk_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset rk_out", rk_out, 128'd0);
        chk("reset rk_index", 128'(rk_index), 128'd0);
        chk("reset rk_valid", 128'(rk_valid), 128'd0);
        chk("reset key_busy", 128'(key_busy), 128'd0);
        chk("reset expand_done", 128'(expand_done), 128'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // T1: FIPS-197 A.1, full throughput
        push_a1();
        start_key(a1_keys[0]);
        chk("T1 busy after start", 128'(key_busy), 128'd1);
        chk("T1 valid after start", 128'(rk_valid), 128'd1);
        drain("T1", 100, -1, '0, 1'b0, cyc);
        chk("T1 done latency", 128'(cyc + 1), 128'd12);

        // T3: random backpressure
        push_a1();
        start_key(a1_keys[0]);
        drain("T3", 50, -1, '0, 1'b0, cyc);

        // T4: start while busy is ignored, then the all-ff key runs normally
        push_a1();
        start_key(a1_keys[0]);
        drain("T4", 100, 4, '1, 1'b0, cyc);
        push_sparse('1, 128'he8e9e9e917161616e8e9e9e917161616, '0, 1'b0);
        start_key('1);
        drain("T4 ff", 100, -1, '0, 1'b0, cyc);

        // T5: reset at idx6
        rk_ready = 1'b1;
        start_key(a1_keys[0]);
        for (int i = 0; i < 20 && !(rk_valid && rk_index == 4'd6); i++) begin
            @(posedge clk); #1;
        end
        chk("T5 reached idx6", 128'(rk_index), 128'd6);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("T5 rk_out", rk_out, 128'd0);
        chk("T5 rk_index", 128'(rk_index), 128'd0);
        chk("T5 rk_valid", 128'(rk_valid), 128'd0);
        chk("T5 key_busy", 128'(key_busy), 128'd0);
        chk("T5 expand_done", 128'(expand_done), 128'd0);
        saw_done = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (expand_done) saw_done = 1;
        end
        chk("T5 no done after reset", 128'(saw_done), 128'd0);

        // T2: FIPS-197 C.1 after the reset
        push_sparse(128'h000102030405060708090a0b0c0d0e0f, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
                    128'h13111d7fe3944a17f307a78b4d2b30c5, 1'b1);
        start_key(128'h000102030405060708090a0b0c0d0e0f);
        drain("T2", 100, -1, '0, 1'b0, cyc);

        // T6: all-zero key, with a key_start landing in the DONE cycle
        push_sparse('0, 128'h62636363626363636263636362636363,
                    128'hb4ef5bcb3e92e21123e951cf6f8f188e, 1'b1);
        start_key('0);
        drain("T6", 70, -1, '0, 1'b1, cyc);
        @(posedge clk); #1;
        chk("T6 start in DONE ignored", 128'(rk_valid), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
